// File: rtl/amber48_uart_pkg.sv
// Shared definitions for the amber48 UART blocks.
// Holds the receiver state encoding and the baud divisor helper.
package amber48_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_rx_state_e;

    // Rounded clocks per bit; the TX block shares this.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/amber48_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// RST_VAL selects the value both flops take during reset.
module amber48_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/amber48_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a valid/ready output.
// Define AMBER48_UART_RX_GLITCH_FILTER_EN for 3-sample majority voting.
module amber48_uart_rx
    import amber48_uart_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 27_000_000,
    parameter int BAUD_RATE     = 115_200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int CPB  = clks_per_bit(CLOCK_FREQ_HZ, BAUD_RATE);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);

    localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_LD = CW'(CPB - 1);

    generate
        if (CPB < 4) begin : g_bad_rate
            $fatal(1, "amber48_uart_rx: CLKS_PER_BIT below 4");
        end
    endgenerate

    logic rx_s;
    logic sample;

    amber48_sync2 #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (rx_i),
        .q_o  (rx_s)
    );

`ifdef AMBER48_UART_RX_GLITCH_FILTER_EN
    // Two past values plus the current one form the 3-cycle window.
    logic [1:0] hist_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign sample = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) |
                    (hist_q[0] & hist_q[1]);
`else
    assign sample = rx_s;
`endif

    uart_rx_state_e state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           ferr_q, ferr_d;
    logic           ovr_q, ovr_d;
    logic           tick;

    assign tick = (cnt_q == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HALF_LD;
                    state_d = START;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!sample) begin
                    cnt_d   = FULL_LD;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {sample, shift_q[7:1]};
                    cnt_d   = FULL_LD;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (sample) begin
                    state_d = IDLE;
                    // A same-cycle accept frees the slot for the new byte.
                    if (!valid_q || ready_i) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    ferr_d  = 1'b1;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;

endmodule
